// File: rtl/sys_array_result_streamer_if.sv
// Element-serial result stream: one matrix element per valid/ready beat, tagged
// with its row/column position and a last flag on the final element.
interface sys_array_result_streamer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ARRAY_W_W  = 5,
  parameter int ARRAY_A_L  = 5
);
  localparam int RW = (ARRAY_W_W > 1) ? $clog2(ARRAY_W_W) : 1;
  localparam int CW = (ARRAY_A_L > 1) ? $clog2(ARRAY_A_L) : 1;

  logic                    m_valid;
  logic                    m_ready;
  logic [2*DATA_WIDTH-1:0] m_data;
  logic [RW-1:0]           m_row;
  logic [CW-1:0]           m_col;
  logic                    m_last;

  modport master (
    output m_valid, m_data, m_row, m_col, m_last,
    input  m_ready
  );

  modport slave (
    input  m_valid, m_data, m_row, m_col, m_last,
    output m_ready
  );
endinterface

// File: rtl/sys_array_result_streamer.sv
// Snapshots the systolic array result matrix on a rising fetch_ready and replays
// it row-major as an element stream, freeing the array for its next job.
module sys_array_result_streamer #(
  parameter int DATA_WIDTH = 8,
  parameter int ARRAY_W_W  = 5,
  parameter int ARRAY_A_L  = 5
) (
  input  logic                                                 clk,
  input  logic                                                 reset,
  input  logic                                                 fetch_ready,
  input  logic [0:ARRAY_W_W-1][0:ARRAY_A_L-1][2*DATA_WIDTH-1:0] fetch_data,
  sys_array_result_streamer_if.master                          strm,
  output logic                                                 busy,
  output logic                                                 done,
  output logic                                                 overrun,
  input  logic                                                 clr_overrun
);

  localparam int RW = (ARRAY_W_W > 1) ? $clog2(ARRAY_W_W) : 1;
  localparam int CW = (ARRAY_A_L > 1) ? $clog2(ARRAY_A_L) : 1;
  localparam logic [RW-1:0] ROW_MAX = RW'(ARRAY_W_W - 1);
  localparam logic [CW-1:0] COL_MAX = CW'(ARRAY_A_L - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic                                                 fetch_ready_q;
  logic                                                 cap;
  logic                                                 beat;
  logic                                                 last_el;
  logic [RW-1:0]                                        row;
  logic [CW-1:0]                                        col;
  logic [0:ARRAY_W_W-1][0:ARRAY_A_L-1][2*DATA_WIDTH-1:0] snapshot;

  assign cap     = fetch_ready & ~fetch_ready_q;
  assign last_el = (row == ROW_MAX) && (col == COL_MAX);
  // m_ready only counts while an element is actually offered.
  assign beat    = (state == STREAM) && strm.m_ready;

  // Stage 0: edge detect, state register and the sticky overrun flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      fetch_ready_q <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      state         <= state_nxt;
      fetch_ready_q <= fetch_ready;
      if (cap && (state != IDLE)) begin
        overrun <= 1'b1;
      end else if (clr_overrun) begin
        overrun <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      row <= '0;
      col <= '0;
    end else if ((state == IDLE) && cap) begin
      row <= '0;
      col <= '0;
    end else if (beat) begin
      if (last_el) begin
        row <= '0;
        col <= '0;
      end else if (col == COL_MAX) begin
        col <= '0;
        row <= row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // Snapshot is pure data: only loaded on an accepted capture, never reset.
  always_ff @(posedge clk) begin
    if ((state == IDLE) && cap) begin
      snapshot <= fetch_data;
    end
  end

  // Stage 1: element select and stream/status outputs
  always_comb begin
    state_nxt    = state;
    strm.m_valid = 1'b0;
    strm.m_data  = '0;
    strm.m_row   = '0;
    strm.m_col   = '0;
    strm.m_last  = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (state)
      IDLE: begin
        if (cap) begin
          state_nxt = STREAM;
        end
      end
      STREAM: begin
        strm.m_valid = 1'b1;
        strm.m_data  = snapshot[row][col];
        strm.m_row   = row;
        strm.m_col   = col;
        strm.m_last  = last_el;
        busy         = 1'b1;
        if (strm.m_ready && last_el) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sys_array_result_streamer.sv
// Scoreboard bench: stimulus queues expected beats, negedge monitors compare every
// offered element against the queue head and pop on each accepted handshake.
module tb_sys_array_result_streamer;

  typedef struct packed {
    logic [15:0] data;
    logic [2:0]  row;
    logic [2:0]  col;
    logic        last;
  } beat_t;

  logic clk;
  logic reset;
  logic fr5, fr2;
  logic clr5, clr2;
  logic [0:4][0:4][15:0] fd5;
  logic [0:1][0:4][15:0] fd2;
  logic busy5, done5, overrun5;
  logic busy2, done2, overrun2;

  sys_array_result_streamer_if #(.DATA_WIDTH(8), .ARRAY_W_W(5), .ARRAY_A_L(5)) s5();
  sys_array_result_streamer_if #(.DATA_WIDTH(8), .ARRAY_W_W(2), .ARRAY_A_L(5)) s2();

  sys_array_result_streamer #(.DATA_WIDTH(8), .ARRAY_W_W(5), .ARRAY_A_L(5)) u5 (
    .clk(clk), .reset(reset), .fetch_ready(fr5), .fetch_data(fd5), .strm(s5),
    .busy(busy5), .done(done5), .overrun(overrun5), .clr_overrun(clr5)
  );

  sys_array_result_streamer #(.DATA_WIDTH(8), .ARRAY_W_W(2), .ARRAY_A_L(5)) u2 (
    .clk(clk), .reset(reset), .fetch_ready(fr2), .fetch_data(fd2), .strm(s2),
    .busy(busy2), .done(done2), .overrun(overrun2), .clr_overrun(clr2)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  beat_t q5[$];
  beat_t q2[$];
  beat_t e5, e2;
  int n_beats5 = 0, n_done5 = 0, first_valid5 = -1, last_beat5 = -1, done_cyc5 = -1;
  int n_beats2 = 0, n_done2 = 0;
  logic prev_v5 = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load5(input logic [15:0] base);
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 5; j++) begin
        fd5[i][j] = base + 16'(i * 256 + j);
        q5.push_back('{data: base + 16'(i * 256 + j), row: 3'(i), col: 3'(j),
                       last: (i == 4 && j == 4)});
      end
    end
  endtask

  task automatic load2(input logic [15:0] base);
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 5; j++) begin
        fd2[i][j] = base + 16'(i * 256 + j);
        q2.push_back('{data: base + 16'(i * 256 + j), row: 3'(i), col: 3'(j),
                       last: (i == 1 && j == 4)});
      end
    end
  endtask

  task automatic wait_done5(input int base, input int limit);
    int t = 0;
    while (n_done5 == base && t < limit) begin
      @(negedge clk);
      t++;
    end
    check("done5_timeout", 32'(n_done5 != base), 32'd1);
  endtask

  // Monitor for the 5x5 instance
  always @(negedge clk) begin
    if (!reset) begin
      if (s5.m_valid && !prev_v5) first_valid5 = cyc;
      prev_v5 = s5.m_valid;
      if (s5.m_valid) begin
        if (q5.size() == 0) begin
          check("s5_unexpected_beat", 32'(s5.m_valid), 32'd0);
        end else begin
          e5 = q5[0];
          check("s5_data", 32'(s5.m_data), 32'(e5.data));
          check("s5_row",  32'(s5.m_row),  32'(e5.row));
          check("s5_col",  32'(s5.m_col),  32'(e5.col));
          check("s5_last", 32'(s5.m_last), 32'(e5.last));
          if (s5.m_ready) begin
            if (s5.m_last) last_beat5 = cyc;
            void'(q5.pop_front());
            n_beats5++;
          end
        end
      end
      if (done5) begin
        n_done5++;
        done_cyc5 = cyc;
      end
    end else begin
      prev_v5 = 1'b0;
    end
  end

  // Monitor for the 2x5 instance
  always @(negedge clk) begin
    if (!reset) begin
      if (s2.m_valid) begin
        if (q2.size() == 0) begin
          check("s2_unexpected_beat", 32'(s2.m_valid), 32'd0);
        end else begin
          e2 = q2[0];
          check("s2_data", 32'(s2.m_data), 32'(e2.data));
          check("s2_row",  32'(s2.m_row),  32'(e2.row));
          check("s2_col",  32'(s2.m_col),  32'(e2.col));
          check("s2_last", 32'(s2.m_last), 32'(e2.last));
          if (s2.m_ready) begin
            void'(q2.pop_front());
            n_beats2++;
          end
        end
      end
      if (done2) n_done2++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k, nd, bb, t;
    reset = 1'b1;
    fr5 = 1'b0; fr2 = 1'b0; clr5 = 1'b0; clr2 = 1'b0;
    fd5 = '0; fd2 = '0;
    s5.m_ready = 1'b0; s2.m_ready = 1'b0;
    repeat (3) tick();
    reset = 1'b0;

    // Reset state
    check("rst_m_valid", 32'(s5.m_valid), 32'd0);
    check("rst_m_data",  32'(s5.m_data),  32'd0);
    check("rst_m_last",  32'(s5.m_last),  32'd0);
    check("rst_busy",    32'(busy5),      32'd0);
    check("rst_done",    32'(done5),      32'd0);
    check("rst_overrun", 32'(overrun5),   32'd0);
    check("rst_s2_valid", 32'(s2.m_valid), 32'd0);

    // Basic drain with m_ready held high
    load5(16'h0000);
    s5.m_ready = 1'b1;
    tick();
    k = cyc;
    fr5 = 1'b1;
    tick();
    fr5 = 1'b0;
    nd = n_done5;
    wait_done5(nd, 100);
    check("basic_first_valid_cyc", 32'(first_valid5), 32'(k + 1));
    check("basic_last_beat_cyc",   32'(last_beat5),   32'(k + 25));
    check("basic_done_cyc",        32'(done_cyc5),    32'(k + 26));
    tick();
    check("basic_done_one_cycle", 32'(done5), 32'd0);
    check("basic_busy_idle",      32'(busy5), 32'd0);

    // Backpressure: m_ready pattern 1,0,0,1
    load5(16'h1000);
    bb = n_beats5;
    nd = n_done5;
    fr5 = 1'b1;
    t = 0;
    while (n_done5 == nd && t < 300) begin
      s5.m_ready = ((t % 4) == 0) || ((t % 4) == 3);
      if (t == 1) fr5 = 1'b0;
      if (t == 6) check("bp_busy", 32'(busy5), 32'd1);
      tick();
      t++;
    end
    check("bp_timeout", 32'(n_done5 != nd), 32'd1);
    check("bp_beats",   32'(n_beats5 - bb), 32'd25);

    // Snapshot isolation and overrun during the stream
    load5(16'h2000);
    bb = n_beats5;
    nd = n_done5;
    fr5 = 1'b1;
    t = 0;
    while (n_done5 == nd && t < 300) begin
      s5.m_ready = (t % 2) == 0;
      if (t == 6) begin
        for (int i = 0; i < 5; i++)
          for (int j = 0; j < 5; j++) fd5[i][j] = 16'hFFFF;
      end
      if (t == 9)  fr5 = 1'b0;
      if (t == 10) fr5 = 1'b1;
      if (t == 14) check("ovr_set_midstream", 32'(overrun5), 32'd1);
      tick();
      t++;
    end
    check("iso_timeout", 32'(n_done5 != nd), 32'd1);
    check("iso_beats",   32'(n_beats5 - bb), 32'd25);
    tick();
    check("ovr_sticky", 32'(overrun5), 32'd1);
    clr5 = 1'b1;
    tick();
    clr5 = 1'b0;
    check("ovr_cleared", 32'(overrun5), 32'd0);

    // Second stream after done, no overrun
    fr5 = 1'b0;
    tick();
    load5(16'h3000);
    bb = n_beats5;
    nd = n_done5;
    s5.m_ready = 1'b1;
    fr5 = 1'b1;
    wait_done5(nd, 100);
    check("second_beats",   32'(n_beats5 - bb), 32'd25);
    check("second_overrun", 32'(overrun5),      32'd0);

    // Capture coinciding with the last handshake, clr_overrun at the same edge
    tick();
    fr5 = 1'b0;
    tick();
    load5(16'h4000);
    nd = n_done5;
    fr5 = 1'b1;
    tick();
    fr5 = 1'b0;
    repeat (24) @(posedge clk);
    #1;
    fr5 = 1'b1;
    clr5 = 1'b1;
    tick();
    clr5 = 1'b0;
    check("ovr_last_beat_set_wins", 32'(overrun5), 32'd1);
    wait_done5(nd, 20);
    repeat (3) tick();
    check("ovr_dropped_no_stream", 32'(s5.m_valid), 32'd0);
    check("ovr_dropped_queue",     32'(q5.size()),  32'd0);

    // Reset mid-stream, then restart with fetch_ready held high
    fr5 = 1'b0;
    tick();
    load5(16'h5000);
    bb = n_beats5;
    s5.m_ready = 1'b1;
    fr5 = 1'b1;
    t = 0;
    while (n_beats5 < bb + 7 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("rms_reached_beat7", 32'(n_beats5 - bb), 32'd7);
    check("rms_overrun_before", 32'(overrun5), 32'd1);
    nd = n_done5;
    tick();
    reset = 1'b1;
    tick();
    check("rms_m_valid", 32'(s5.m_valid), 32'd0);
    check("rms_m_data",  32'(s5.m_data),  32'd0);
    check("rms_m_row",   32'(s5.m_row),   32'd0);
    check("rms_m_col",   32'(s5.m_col),   32'd0);
    check("rms_m_last",  32'(s5.m_last),  32'd0);
    check("rms_busy",    32'(busy5),      32'd0);
    check("rms_done",    32'(done5),      32'd0);
    check("rms_overrun", 32'(overrun5),   32'd0);
    q5.delete();
    load5(16'h6000);
    bb = n_beats5;
    k = cyc;
    reset = 1'b0;
    repeat (2) tick();
    check("rms_no_done_pulse", 32'(n_done5), 32'(nd));
    wait_done5(nd, 100);
    check("rms_restart_first_valid", 32'(first_valid5), 32'(k + 1));
    check("rms_restart_beats",       32'(n_beats5 - bb), 32'd25);

    // 2x5 instance
    load2(16'h0000);
    s2.m_ready = 1'b1;
    fr2 = 1'b1;
    tick();
    fr2 = 1'b0;
    t = 0;
    while (n_done2 == 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("p2_done",  32'(n_done2),   32'd1);
    check("p2_beats", 32'(n_beats2),  32'd10);
    check("p2_queue", 32'(q2.size()), 32'd0);
    check("p5_queue", 32'(q5.size()), 32'd0);

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sys_array_result_streamer.md
Name: sys_array_result_streamer

Overview:
- Drains the result matrix from sys_array_fetcher and turns it into an element-serial stream.
- Snapshots the full out_data bus when the fetcher's ready rises, then emits one element per accepted beat over a valid/ready interface, in row-major order.
- Decouples the array from slow downstream consumers, for example a memory writer or host bridge, so the array can be restarted as soon as the snapshot is taken.

Parameters:
- DATA_WIDTH, 8, operand width; result elements are 2*DATA_WIDTH bits.
- ARRAY_W_W, 5, result rows (weight-matrix rows).
- ARRAY_A_L, 5, result columns (data-matrix columns).
- Derived: N_EL = ARRAY_W_W*ARRAY_A_L; RW = max(1,$clog2(ARRAY_W_W)); CW = max(1,$clog2(ARRAY_A_L)).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- fetch_ready  in  1  ready level from sys_array_fetcher.
- fetch_data  in  [0:ARRAY_W_W-1][0:ARRAY_A_L-1][2*DATA_WIDTH-1:0]  fetcher out_data.
- m_valid  out  1  stream element valid.
- m_ready  in  1  downstream accept.
- m_data  out  2*DATA_WIDTH  element value.
- m_row  out  RW  row index of the current element.
- m_col  out  CW  column index of the current element.
- m_last  out  1  high with the final element (row ARRAY_W_W-1, col ARRAY_A_L-1).
- busy  out  1  high in STREAM and DONE.
- done  out  1  one-cycle pulse after the last beat is accepted.
- overrun  out  1  sticky; a result arrived while busy and was dropped.
- clr_overrun  in  1  clears overrun.

Behaviour:
- Reset (synchronous): state=IDLE. m_valid, m_data, m_row, m_col, m_last, busy, done, overrun, and the fetch_ready delay register all go to 0.
- Capture trigger: cap = fetch_ready & ~fetch_ready_q, where fetch_ready_q is fetch_ready registered each cycle.
  - fetch_ready already high in the first cycle after reset counts as an edge.
- IDLE:
  - On cap, latch all of fetch_data into the snapshot register in that same edge.
  - Set row=col=0 and go to STREAM.
  - m_valid rises the next cycle, giving 1-cycle latency from the sampled edge to the first valid.
- STREAM:
  - m_valid=1. m_data = snapshot[m_row][m_col].
  - m_last = (m_row==ARRAY_W_W-1)&&(m_col==ARRAY_A_L-1).
  - On m_valid&&m_ready, advance:
    - col+1; when col wraps at ARRAY_A_L-1, col=0 and row+1.
    - If the beat had m_last, go to DONE with m_valid=0.
  - Without m_ready, m_data, m_row, m_col and m_last stay stable (AXI-stream hold rule).
- DONE: done=1 for exactly one cycle, then IDLE. busy drops on entry to IDLE.
- Throughput: one element per cycle with m_ready held high, so N_EL consecutive beats.
  - cap → first valid: 1 cycle. Last beat → done: 1 cycle. done → next capture possible: 1 cycle.
- Overrun:
  - cap while in STREAM or DONE sets overrun=1. The snapshot and the stream are unaffected and the new result is lost.
  - cap on the same cycle as the last handshake also counts as overrun.
  - clr_overrun clears overrun. If clr_overrun and a new overrun event coincide, set wins.
- fetch_data changing during STREAM has no effect; only the snapshot is read.
- Reset mid-stream: abort immediately. m_valid=0 next cycle, no done pulse, overrun cleared.
- m_ready is ignored while m_valid=0.

Test Plan:
- Basic drain:
  - Stimulus: defaults (5x5), fetch_data[i][j]=16'h0100*i+j, pulse fetch_ready, m_ready=1.
  - Response: 25 beats on consecutive cycles with values 0000,0001…0004,0100…0404; m_row/m_col match; m_last only on 0404; done pulse 1 cycle after.
- Backpressure:
  - Stimulus: m_ready toggled 1,0,0,1 repeatedly.
  - Response: no value is skipped or duplicated; m_data, m_row, m_col stay stable while stalled; 25 accepted beats total, in order.
- Snapshot isolation:
  - Stimulus: after the capture, drive fetch_data to all 16'hFFFF mid-stream.
  - Response: the stream still emits the original values.
- Overrun:
  - Stimulus: during the stream, drop and re-raise fetch_ready.
  - Response: overrun=1 and stays set; the current stream completes unchanged; clr_overrun returns it to 0.
  - Stimulus: raise fetch_ready again after done.
  - Response: a second full stream of 25 beats with no overrun.
- Reset mid-stream:
  - Stimulus: assert reset after beat 7.
  - Response: all outputs 0 the next cycle and no done pulse.
  - Stimulus: after reset, fetch_ready held high.
  - Response: a new capture and a fresh stream starting at (0,0).
- Parameter sweep:
  - Stimulus: ARRAY_W_W=2, ARRAY_A_L=5.
  - Response: 10 beats, m_last on (1,4), col wraps to 0 after 4.
